// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline stall/flush sequencing for the 5-stage MIPS-Lite core,
//               including the multi-cycle DIVU sequencer and a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_div_start,
    input  logic             id_reads_hilo,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             div_start,
    output logic             div_busy,
    output logic             hilo_wr,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int               CW        = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0]    CNT_INIT  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(1);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_load_use;
    logic w_div_hz;

    always_comb begin
        w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        w_div_hz   = (state_q != IDLE) && (id_div_start || id_reads_hilo);
    end

    // Branch flush outranks any stall: the ID instruction is wrong-path anyway.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use || w_div_hz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // The start cycle counts as busy: the divider latches its operands there,
    // so busy spans DIV_CYCLES+1 cycles and hilo_wr lands DIV_CYCLES after start.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_start = 1'b0;
        div_busy  = 1'b0;
        hilo_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_div_start && !ex_branch_taken && !w_load_use) begin
                    div_start = 1'b1;
                    div_busy  = 1'b1;
                    cnt_d     = CNT_INIT;
                    state_d   = DIV_RUN;
                end
            end
            DIV_RUN: begin
                div_busy = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                div_busy = 1'b1;
                hilo_wr  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Scoreboard bench for hazard_stall_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 16;

    // Control vector bit order: pc_en ifid_en ifid_flush idex_flush div_start div_busy hilo_wr
    localparam logic [6:0] C_RUN = 7'b1100000;
    localparam logic [6:0] C_STL = 7'b0001000;
    localparam logic [6:0] C_BR  = 7'b1111000;
    localparam logic [6:0] C_DS  = 7'b0000100;
    localparam logic [6:0] C_BSY = 7'b0000010;
    localparam logic [6:0] C_HW  = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, id_div_start, id_reads_hilo, ex_mem_read, ex_branch_taken;
    logic             pc_en, ifid_en, ifid_flush, idex_flush;
    logic             div_start, div_busy, hilo_wr;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct packed {
        logic [6:0]       ctl;
        logic [CNT_W-1:0] sc;
    } exp_t;

    exp_t       sbq[$];
    int         tests    = 0;
    int         failures = 0;
    int         cyc_no   = 0;
    logic [CNT_W-1:0] exp_sc = '0;

    hazard_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_div_start    (id_div_start),
        .id_reads_hilo   (id_reads_hilo),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .div_start       (div_start),
        .div_busy        (div_busy),
        .hilo_wr         (hilo_wr),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            exp_t e;
            exp_t g;
            e = sbq.pop_front();
            g = '{ctl: {pc_en, ifid_en, ifid_flush, idex_flush, div_start, div_busy, hilo_wr},
                   sc:  stall_cnt};
            tests++;
            if (g !== e) begin
                failures++;
                $display("FAIL cycle %0d: ctl got %b exp %b, stall_cnt got %0d exp %0d",
                         cyc_no, g.ctl, e.ctl, g.sc, e.sc);
            end
            cyc_no++;
        end
    end

    // One cycle of stimulus plus its expected response; stall_cnt model steps after.
    task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic ds, input logic rh, input logic mr,
                       input logic [4:0] xrt, input logic br, input logic [6:0] ec);
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_div_start = ds;
        id_reads_hilo = rh; ex_mem_read = mr; ex_rt = xrt; ex_branch_taken = br;
        sbq.push_back('{ctl: ec, sc: exp_sc});
        if (r)
            exp_sc = '0;
        else if (!ec[6] && exp_sc != '1)
            exp_sc = exp_sc + 1'b1;
    endtask

    task automatic idle(input logic [6:0] ec);
        cyc(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, ec);
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 0; id_div_start = 0;
        id_reads_hilo = 0; ex_mem_read = 0; ex_rt = '0; ex_branch_taken = 0;
        repeat (2) @(posedge clk);

        // Reset state
        idle(C_RUN);

        // Load-use on rs, then on rt, rt not used, branch override, ex_rt==0
        cyc(0, 5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 0, C_STL);
        idle(C_RUN);
        cyc(0, 5'd0, 5'd7, 1, 0, 0, 1, 5'd7, 0, C_STL);
        cyc(0, 5'd0, 5'd7, 0, 0, 0, 1, 5'd7, 0, C_RUN);
        cyc(0, 5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 1, C_BR);
        cyc(0, 5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, C_RUN);

        // DIVU suppressed by branch and by load-use
        cyc(0, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 1, C_BR);
        cyc(0, 5'd5, 5'd0, 0, 1, 0, 1, 5'd5, 0, C_STL);
        idle(C_RUN);

        // Plain divide; a branch mid-divide must not abort it
        cyc(0, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, C_RUN | C_DS | C_BSY);
        for (int k = 1; k < DIV_CYCLES; k++) begin
            if (k == 10) cyc(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, C_BR | C_BSY);
            else         idle(C_RUN | C_BSY);
        end
        idle(C_RUN | C_BSY | C_HW);
        idle(C_RUN);

        // MFHI arriving 5 cycles after start stalls until the first IDLE cycle
        cyc(0, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, C_RUN | C_DS | C_BSY);
        for (int k = 1; k < 5; k++) idle(C_RUN | C_BSY);
        for (int k = 5; k < DIV_CYCLES; k++)
            cyc(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, C_STL | C_BSY);
        cyc(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, C_STL | C_BSY | C_HW);
        cyc(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, C_RUN);

        // Back-to-back DIVU: second one waits, then starts in the first IDLE cycle
        cyc(0, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, C_RUN | C_DS | C_BSY);
        for (int k = 1; k < DIV_CYCLES; k++)
            cyc(0, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, C_STL | C_BSY);
        cyc(0, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, C_STL | C_BSY | C_HW);
        cyc(0, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, C_RUN | C_DS | C_BSY);
        for (int k = 1; k < DIV_CYCLES; k++) idle(C_RUN | C_BSY);
        idle(C_RUN | C_BSY | C_HW);
        idle(C_RUN);

        // Reset mid-divide (internal count at 10): no hilo_wr afterwards
        cyc(0, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, C_RUN | C_DS | C_BSY);
        for (int k = 1; k < DIV_CYCLES - 10; k++) idle(C_RUN | C_BSY);
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, C_RUN | C_BSY);
        for (int k = 0; k < DIV_CYCLES + 8; k++) idle(C_RUN);

        // Saturation of the stall counter
        for (int k = 0; k < 70000; k++)
            cyc(0, 5'd3, 5'd0, 0, 0, 0, 1, 5'd3, 0, C_STL);
        cyc(0, 5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, C_RUN);
        cyc(0, 5'd9, 5'd9, 1, 0, 0, 1, 5'd0, 0, C_RUN);
        idle(C_RUN);

        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (sbq.size() != 0 || exp_sc != 16'hFFFF) begin
            failures++;
            $display("FAIL drain: queue left %0d entries, model stall_cnt %0d exp 65535",
                     sbq.size(), exp_sc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire
